// File: rtl/kbd_mouse_pkg.sv
// Shared definitions for the keyboard/mouse FIFO register window.
package kbd_mouse_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TYPE   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;

  localparam logic [1:0] KM_MOUSE_X = 2'd0;
  localparam logic [1:0] KM_MOUSE_Y = 2'd1;
  localparam logic [1:0] KM_KBD     = 2'd2;
  localparam logic [1:0] KM_MBTN    = 2'd3;

  localparam int ST_NOT_EMPTY = 7;
  localparam int ST_OVERFLOW  = 6;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACTIVE = 2'd1,
    BUS_DONE   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/kbd_mouse_fifo_sync_fifo.sv
// Single-clock FIFO; a pop in the same clock as a push-while-full frees the slot for that push.
module sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/kbd_mouse_fifo.sv
// Keyboard/mouse byte queue behind a byte-wide 68020 register window on D[31:24].
//   state      | meaning
//   BUS_IDLE   | waiting for a window hit with DS20 low
//   BUS_ACTIVE | read data captured and held, waiting for AS20 release
//   BUS_DONE   | one-clock recovery before the next cycle may start
module kbd_mouse_fifo
  import kbd_mouse_pkg::*;
#(
  parameter logic [7:0] BASE       = 8'hE9,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic        CLKCPU_A,
  input  logic        RESET_n,
  input  logic [7:0]  KBD_MOUSE_DATA,
  input  logic [1:0]  KBD_MOUSE_TYPE,
  input  logic        KBD_MOUSE_STROBE,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW,
  input  logic [23:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        ACCESS
);

  bus_state_e state_q, state_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d, push_q, push_d;
  logic       access_q, access_d, d_oe_q, d_oe_d, pop_pend_q, pop_pend_d;
  logic       overflow_q, overflow_d;
  logic [7:0] d_out_q, d_out_d;

  logic                fifo_full, fifo_empty, fifo_drop, fifo_pop, ovf_clr, hit;
  logic [DEPTH_LOG2:0] fifo_count;
  logic [9:0]          fifo_head;
  logic [1:0]          reg_sel;
  logic [7:0]          rd_byte;
  logic                unused_ok;

  assign unused_ok = ^{A[15:2], D_IN[7], D_IN[5:0], fifo_full};
  assign hit     = ~AS20 && (A[23:16] == BASE);
  assign reg_sel = A[1:0];

  sync_fifo #(.WIDTH(10), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (CLKCPU_A),
    .rst_n     (RESET_n),
    .push      (push_q),
    .push_data ({KBD_MOUSE_TYPE, KBD_MOUSE_DATA}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head),
    .drop      (fifo_drop)
  );

  always_comb begin
    rd_byte = 8'h00;
    case (reg_sel)
      REG_STATUS: begin
        rd_byte[ST_NOT_EMPTY] = ~fifo_empty;
        rd_byte[ST_OVERFLOW]  = overflow_q;
        rd_byte[4:0]          = 5'(fifo_count);
      end
      REG_TYPE: if (!fifo_empty) rd_byte[1:0] = fifo_head[9:8];
      REG_DATA: if (!fifo_empty) rd_byte = fifo_head[7:0];
      default:  rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    sync1_d    = KBD_MOUSE_STROBE;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    push_d     = sync2_q & ~edge_q;
    access_d   = hit;
    state_d    = state_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    pop_pend_d = pop_pend_q;
    ovf_clr    = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (hit && !DS20) begin
          state_d    = BUS_ACTIVE;
          d_out_d    = rd_byte;
          d_oe_d     = RW;
          pop_pend_d = RW && (reg_sel == REG_DATA) && !fifo_empty;
          ovf_clr    = !RW && (reg_sel == REG_STATUS) && D_IN[ST_OVERFLOW];
        end
      end
      BUS_ACTIVE: begin
        if (AS20) begin
          state_d    = BUS_DONE;
          d_oe_d     = 1'b0;
          fifo_pop   = pop_pend_q;
          pop_pend_d = 1'b0;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    // A drop in the same clock as a clear wins so the event is not lost.
    overflow_d = (overflow_q & ~ovf_clr) | fifo_drop;
  end

  always_ff @(posedge CLKCPU_A) begin
    if (!RESET_n) begin
      state_q    <= BUS_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      push_q     <= 1'b0;
      access_q   <= 1'b0;
      d_oe_q     <= 1'b0;
      pop_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      d_out_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      push_q     <= push_d;
      access_q   <= access_d;
      d_oe_q     <= d_oe_d;
      pop_pend_q <= pop_pend_d;
      overflow_q <= overflow_d;
      d_out_q    <= d_out_d;
    end
  end

  assign D_OUT  = d_out_q;
  assign D_OE   = d_oe_q;
  assign ACCESS = access_q;

endmodule

// File: tb/tb_kbd_mouse_fifo.sv
// Randomized bench for kbd_mouse_fifo against a queue-based model of the register window.
module tb_kbd_mouse_fifo;
  import kbd_mouse_pkg::*;

  localparam logic [7:0] WIN = 8'hE9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0, as20 = 1'b1, ds20 = 1'b1, rw = 1'b1;
  logic [7:0]  kdata = 8'h00, d_in = 8'h00;
  logic [1:0]  ktype = 2'd0;
  logic [23:0] a = 24'h0;
  logic [7:0]  d_out;
  logic        d_oe, access;

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0] ent_q[$];
  logic       ovf_m = 1'b0;
  logic [1:0] types [4];

  kbd_mouse_fifo dut (
    .CLKCPU_A        (clk),
    .RESET_n         (rst_n),
    .KBD_MOUSE_DATA  (kdata),
    .KBD_MOUSE_TYPE  (ktype),
    .KBD_MOUSE_STROBE(strobe),
    .AS20            (as20),
    .DS20            (ds20),
    .RW              (rw),
    .A               (a),
    .D_IN            (d_in),
    .D_OUT           (d_out),
    .D_OE            (d_oe),
    .ACCESS          (access)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_reg(input logic [1:0] r);
    int n;
    n = ent_q.size();
    case (r)
      2'd0:    return {(n != 0), ovf_m, 1'b0, 5'(n)};
      2'd1:    return (n != 0) ? {6'b0, ent_q[0][9:8]} : 8'h00;
      2'd2:    return (n != 0) ? ent_q[0][7:0] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_push(input logic [1:0] t, input logic [7:0] d);
    if (ent_q.size() < 16) ent_q.push_back({t, d});
    else ovf_m = 1'b1;
  endtask

  task automatic do_strobe(input logic [1:0] t, input logic [7:0] d);
    ktype = t; kdata = d; strobe = 1'b1;
    repeat (4) tick();
    strobe = 1'b0;
    repeat (3) tick();
    model_push(t, d);
  endtask

  // Full bus cycle starting now; checks outputs and updates the model afterwards.
  task automatic bus_op(input logic [23:0] addr, input logic rd, input logic [7:0] din,
                        input string tag, output logic [7:0] got);
    logic       in_win;
    logic [7:0] exp;
    in_win = (addr[23:16] == WIN);
    exp = model_reg(addr[1:0]);
    a = addr; rw = rd; d_in = din; as20 = 1'b0; ds20 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = d_out;
    check_eq({tag, "_access"}, access, in_win);
    check_eq({tag, "_oe"}, d_oe, in_win & rd);
    if (in_win && rd) check_eq({tag, "_dout"}, d_out, exp);
    @(posedge clk); #1;
    as20 = 1'b1; ds20 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_oe_rel"}, d_oe, 1'b0);
    check_eq({tag, "_acc_rel"}, access, 1'b0);
    tick();
    if (in_win) begin
      if (rd && addr[1:0] == REG_DATA && ent_q.size() != 0) void'(ent_q.pop_front());
      if (!rd && addr[1:0] == REG_STATUS && din[6]) ovf_m = 1'b0;
    end
  endtask

  function automatic logic [23:0] win_addr(input logic [1:0] r);
    return {WIN, 14'($urandom), r};
  endfunction

  initial begin
    logic [7:0] got, exp;
    types[0] = KM_MOUSE_X; types[1] = KM_MOUSE_Y; types[2] = KM_KBD; types[3] = KM_MBTN;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dout", d_out, 8'h00);
    check_eq("rst_oe", d_oe, 1'b0);
    check_eq("rst_access", access, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "st0", got);
    check_eq("st0_val", got, 8'h00);

    // Single keyboard byte: status captured 4 clocks after strobe first sampled.
    ktype = KM_KBD; kdata = 8'h45; strobe = 1'b1;
    repeat (4) tick();
    model_push(KM_KBD, 8'h45);
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "st1", got);
    check_eq("st1_val", got, 8'h81);
    strobe = 1'b0;
    repeat (3) tick();
    bus_op(win_addr(REG_TYPE), 1'b1, 8'h00, "ty1", got);
    check_eq("ty1_val", got, 8'h02);
    bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "dt1", got);
    check_eq("dt1_val", got, 8'h45);
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "st2", got);
    check_eq("st2_val", got, 8'h00);

    // Push must not be visible to a capture 2 clocks after strobe first sampled.
    ktype = KM_MOUSE_X; kdata = 8'h3C; strobe = 1'b1;
    repeat (2) tick();
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "lat", got);
    check_eq("lat_val", got, 8'h00);
    strobe = 1'b0;
    repeat (3) tick();
    model_push(KM_MOUSE_X, 8'h3C);
    bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "lat_dt", got);

    // Overflow: 17 strobes into 16 slots.
    for (int i = 0; i < 17; i++) do_strobe(types[$urandom_range(0, 3)], 8'(i));
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "ovf_st", got);
    check_eq("ovf_st_val", got, 8'hD0);
    for (int i = 0; i < 16; i++) begin
      bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "drain", got);
      check_eq("drain_order", got, 8'(i));
    end
    bus_op(win_addr(REG_STATUS), 1'b0, 8'h40, "ovf_clr", got);
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "clr_st", got);
    check_eq("clr_st_val", got, 8'h00);

    // Full FIFO: push lands on the same edge as a DATA-read pop.
    for (int i = 0; i < 16; i++) do_strobe(types[i % 4], 8'(8'h80 + i));
    exp = model_reg(REG_DATA);
    a = win_addr(REG_DATA); rw = 1'b1; as20 = 1'b0; ds20 = 1'b0;
    @(posedge clk); #1;
    ktype = KM_MBTN; kdata = 8'hA5; strobe = 1'b1;
    tick(); tick(); tick();
    as20 = 1'b1; ds20 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("simul_hold", d_out, exp);
    check_eq("simul_oe", d_oe, 1'b0);
    #5 #1 strobe = 1'b0;
    repeat (4) tick();
    void'(ent_q.pop_front());
    model_push(KM_MBTN, 8'hA5);
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "simul_st", got);
    check_eq("simul_st_val", got, 8'h90);
    for (int i = 0; i < 16; i++) bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "simul_dr", got);
    check_eq("simul_last", got, 8'hA5);

    bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "empty_dt", got);
    check_eq("empty_dt_val", got, 8'h00);
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "empty_st", got);

    // Reset in the middle of an active DATA read.
    for (int i = 0; i < 5; i++) do_strobe(KM_KBD, 8'(8'h10 + i));
    a = win_addr(REG_DATA); rw = 1'b1; as20 = 1'b0; ds20 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_oe", d_oe, 1'b0);
    check_eq("mid_rst_acc", access, 1'b0);
    check_eq("mid_rst_dout", d_out, 8'h00);
    #1 as20 = 1'b1; ds20 = 1'b1;
    tick();
    rst_n = 1'b1;
    ent_q.delete();
    ovf_m = 1'b0;
    tick();
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "post_rst", got);
    check_eq("post_rst_val", got, 8'h00);

    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_strobe(types[$urandom_range(0, 3)], 8'($urandom));
      end else if (op <= 5) begin
        bus_op(win_addr(REG_DATA), 1'b1, 8'h00, "rnd_dt", got);
      end else if (op == 6) begin
        bus_op(win_addr(2'($urandom_range(0, 3))), 1'b1, 8'h00, "rnd_rd", got);
      end else if (op == 7) begin
        bus_op(win_addr(REG_STATUS), 1'b0, 8'($urandom), "rnd_wst", got);
      end else if (op == 8) begin
        bus_op(win_addr(2'($urandom_range(1, 3))), 1'b0, 8'($urandom), "rnd_wr", got);
      end else begin
        logic [7:0] hi;
        hi = 8'($urandom);
        if (hi == WIN) hi = ~hi;
        bus_op({hi, 16'($urandom)}, 1'($urandom), 8'($urandom), "rnd_miss", got);
      end
    end
    bus_op(win_addr(REG_STATUS), 1'b1, 8'h00, "final_st", got);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_mouse_fifo.md
Name: kbd_mouse_fifo

Overview:
- Downstream consumer of the SPI user-io channel's keyboard/mouse stream (KBD_MOUSE_DATA/TYPE/STROBE).
- Resynchronises each strobe into the CPU clock domain and queues {type, data} in a 16-entry FIFO.
- Exposes status, type and data registers to the 68020 bus as a byte-wide window on D[31:24].
- The top level owns the tristate on D[31:24] and combines ACCESS with PUNT handling.

Parameters:
BASE, 8'hE9, A[23:16] match value for the register window
DEPTH_LOG2, 4, FIFO depth exponent (depth 16)

Ports:
CLKCPU_A  input  1  sole clock; all logic on rising edge
RESET_n  input  1  synchronous reset, active-low
KBD_MOUSE_DATA  input  8  byte from SPI user-io, stable ≥4 CLKCPU_A cycles after STROBE rises
KBD_MOUSE_TYPE  input  2  0 mouse X, 1 mouse Y, 2 keyboard, 3 mouse buttons
KBD_MOUSE_STROBE  input  1  async pulse from SPI domain; rising edge = new byte
AS20  input  1  address strobe, active-low
DS20  input  1  data strobe, active-low
RW  input  1  1 = read, 0 = write
A  input  24  CPU address
D_IN  input  8  D[31:24] as seen by the block (write data)
D_OUT  output  8  read data
D_OE  output  1  top drives D[31:24] from D_OUT when high
ACCESS  output  1  high while a bus cycle hits the window (top uses it to suppress punting)

Behaviour:
- Reset (RESET_n low at a clock edge): FIFO empty, count 0, overflow 0, D_OUT 8'h00, D_OE 0, ACCESS 0, sync/edge flops 0. Any in-flight bus cycle or strobe is abandoned; a pending pop does not occur.
- Strobe path:
  - two-flop synchroniser, then an edge register; push is a 1-cycle pulse on the synchronised 0→1 edge.
  - {TYPE, DATA} is sampled in the push cycle; the entry is visible in count 3 clocks after STROBE first sampled high.
- Push when count=16: entry dropped, overflow set (sticky), count stays 16.
- Window hit: AS20=0 and A[23:16]=BASE, sampled each clock. ACCESS is registered and rises 1 clock after the hit is sampled.
- Registers, selected by A[1:0]:
  - 0 STATUS read: [7] not-empty, [6] overflow, [5] 0, [4:0] count 0..16.
  - 0 STATUS write: D_IN[6]=1 clears overflow.
  - 1 TYPE read: [7:2] 0, [1:0] head type (00 if empty).
  - 2 DATA read: head byte (00 if empty).
  - 3: reads 00; writes ignored.
- Bus FSM states IDLE → ACTIVE → DONE:
  - IDLE→ACTIVE when hit and DS20=0 are both sampled. In that clock, capture read data into D_OUT, set D_OE=RW, and perform any write action.
  - ACTIVE: D_OUT is held constant for the whole cycle, even if a push changes the head.
  - ACTIVE→DONE when AS20=1 is sampled; D_OE and ACCESS drop that cycle.
  - DONE→IDLE unconditionally on the next clock.
- Pop: one per bus cycle, on the ACTIVE→DONE transition, only if the cycle was a DATA read and the FIFO was non-empty at capture. A read of an empty FIFO returns 00, pops nothing and has no error flag.
- Simultaneous push and pop: both occur; count unchanged. When full, the pop frees the slot first, so the push succeeds and overflow is not set.
- Pointers wrap modulo 16; count is a 5-bit value. A[15:2] is don't-care (registers alias throughout the window).

Decomposition:
- Package kbd_mouse_pkg:
  - REG_STATUS=0, REG_TYPE=1, REG_DATA=2
  - type codes KM_MOUSE_X/Y, KM_KBD, KM_MBTN
  - bus state enum
  - STATUS bit indices
- Sub-module sync_fifo (parameterised width 10, depth 2^DEPTH_LOG2; push/pop/full/empty/count/head; full-with-simultaneous-pop rule implemented inside).
- Synchroniser and bus FSM live in the top of this block.

Test Plan:
- Reset, then read STATUS → D_OUT 8'h00, D_OE high only between the capture clock and AS20 release; ACCESS never high for A[23:16]≠BASE.
- Strobe with TYPE=2, DATA=8'h45 → after 3 clocks STATUS=8'h81. TYPE read → 8'h02. DATA read → 8'h45, then STATUS=8'h00.
- 17 strobes, data 0..16 → STATUS=8'hD0. Sixteen DATA reads return 0..15 in order. Write STATUS with 8'h40 → STATUS=8'h00.
- With 16 entries queued, land a strobe push in the same clock as a DATA-read pop → count stays 16, overflow stays 0, newest byte is last out.
- DATA read on empty FIFO → 8'h00, count stays 0. Assert RESET_n low mid-ACTIVE with 5 entries queued → next clock D_OE=0, ACCESS=0, STATUS reads 8'h00.
